// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - requester-side bundle of serial_add_ctrl (start/operands/result); sub exists only with SERIAL_ADD_SUB_EN
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start, op_a, op_b,
    input  busy, done, result, cout
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start, op_a, op_b,
    output busy, done, result, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add sequencer over one external full adder; SERIAL_ADD_SUB_EN adds subtract
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_add_ctrl_if.slave    bus,
  output logic                fa_a,
  output logic                fa_b,
  output logic                fa_cin,
  input  logic                fa_sum,
  input  logic                fa_cout
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] r_sh_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             sub_q;
  logic [WIDTH-1:0] r_next;

  // Result register after this bit's sum is shifted in from the top
  assign r_next = {fa_sum, r_sh_q[WIDTH-1:1]};

  // Adder inputs only toggle while bits are being processed
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state_q == RUN) begin
      fa_a   = a_sh_q[0];
      fa_b   = b_sh_q[0] ^ sub_q;
      fa_cin = carry_q;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;

  // Sequencer: accept, shift one bit per cycle, publish result, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      sub_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sh_q  <= bus.op_a;
            b_sh_q  <= bus.op_b;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            // Two's complement subtract: invert b bits and seed carry with 1
            sub_q   <= bus.sub;
            carry_q <= bus.sub;
`else
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
`endif
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          r_sh_q  <= r_next;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_q <= r_next;
            cout_q   <= fa_cout;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial sequencer that time-shares a single external 1-bit full adder (built from the team's CMOS gate cells) to add two WIDTH-bit operands, LSB first. It sits between a simple start/done requester and one `full_adder` instance.
- Latches the operands.
- Drives the adder one bit per cycle.
- Holds the carry in a flip-flop.
- Assembles the result by shifting.

## Interface
- `WIDTH`, default 8, operand/result width; legal range 2..32.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op_a`  in  WIDTH  addend A; sampled with the accepted `start`.
- `op_b`  in  WIDTH  addend B; sampled with the accepted `start`.
- `sub`  in  1  subtract select; port exists only with `SERIAL_ADD_SUB_EN`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; `result`/`cout` valid.
- `result`  out  WIDTH  sum; held until the next accepted `start`.
- `cout`  out  1  final carry; held like `result`.
- `fa_a`  out  1  to full adder input a.
- `fa_b`  out  1  to full adder input b.
- `fa_cin`  out  1  to full adder carry-in.
- `fa_sum`  in  1  from full adder sum.
- `fa_cout`  in  1  from full adder carry-out.

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - `a_sh` and `b_sh` (WIDTH each): operand shift registers.
  - `r_sh` (WIDTH): result shift register.
  - `carry_q`: carry flip-flop.
  - `cnt`: bit counter, `$clog2(WIDTH+1)` bits.
- IDLE, `start`=1 at an edge:
  - Load `a_sh`=`op_a`, `b_sh`=`op_b`, `cnt`=0, `carry_q`=0 (see Configuration).
  - Go to RUN.
  - `result`/`cout` are not cleared until the operation completes.
- RUN:
  - `fa_a`=`a_sh[0]`, `fa_b`=`b_sh[0]`, `fa_cin`=`carry_q` (combinational).
  - Each edge:
    - `a_sh`/`b_sh` shift right.
    - `r_sh` = {`fa_sum`, `r_sh[WIDTH-1:1]`}.
    - `carry_q`=`fa_cout`.
    - `cnt`+1.
  - When `cnt`=WIDTH-1 at an edge: copy the final shifted value into `result`, copy `fa_cout` into `cout`, go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `fa_a`/`fa_b`/`fa_cin` are driven 0 outside RUN.
- `start` in RUN or DONE is ignored; it is not queued.
- Arithmetic: `result` = (`op_a`+`op_b`) mod 2^WIDTH; `cout` = bit WIDTH of the true sum.

## Timing
- Reset values (asynchronous, while `rst_n`=0): state IDLE, `busy`=0, `done`=0, `result`=0, `cout`=0, all shift registers, `carry_q` and `cnt` 0, `fa_*`=0.
- Reset asserted mid-operation aborts immediately; no `done` is produced.
- Edge E0 accepts `start`; `busy` rises after E0.
- Edges E1..E(WIDTH) process bits 0..WIDTH-1.
- `done`=1 in the cycle after E(WIDTH); `result` and `cout` change at E(WIDTH).
- `busy` falls after E(WIDTH+1).
- Earliest next acceptance is E(WIDTH+2), giving one operation per WIDTH+2 cycles.
- The external adder path is combinational: `fa_a`/`fa_b`/`fa_cin` to `fa_sum`/`fa_cout` must settle within one clock period.
- `start` held high continuously starts a new operation at every IDLE.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - The `sub` port exists and is sampled with `start`.
  - When `sub`=1, `fa_b`=~`b_sh[0]` and `carry_q` loads 1 at acceptance.
  - Result is `op_a`-`op_b` mod 2^WIDTH; `cout`=1 means no borrow.
  - A `sub` change during RUN has no effect.
- Not defined: no `sub` port; the block is add only, with behaviour identical to `sub`=0.

## Test plan
WIDTH=8, external full adder model, and a checker on `fa_*` in every scenario.
- `op_a`=0x35, `op_b`=0x4A, `start` pulse → `done` 8 edges after acceptance; `result`=0x7F, `cout`=0; `busy` high 9 cycles; `fa_*`=0 in IDLE.
- `op_a`=0xFF, `op_b`=0x01 → `result`=0x00, `cout`=1. Then 0xAA+0x55 back-to-back with `start` held high → second acceptance exactly 10 cycles after the first; `result`=0xFF, `cout`=0.
- `start` pulses with different operands at RUN cycle 3 and in the DONE cycle → ignored; exactly one `done`, with the first operation's result.
- `rst_n` low in RUN cycle 4 → `busy`/`done`/`result`/`cout` 0 immediately; no `done` after release; a following 0x01+0x02 gives 0x03.
- With `SERIAL_ADD_SUB_EN`:
  - 0x10−0x01 → `result`=0x0F, `cout`=1.
  - 0x00−0x01 → `result`=0xFF, `cout`=0.
  - 0x80−0x80 → `result`=0x00, `cout`=1.
- Random sweep of 1000 operand pairs, including `op_a`=`op_b`=0 and both 0xFF → every `result`/`cout` matches the golden sum (and difference with the macro).
